// File: rtl/spi_ctrl_pkg.sv
// Shared types and sizing helpers for the SPI request arbiter.
package spi_ctrl_pkg;

   localparam int SPI_WORD_W = 8;

   // Transfer sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RESP    = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   // Width of a counter that has to hold values 0..cycles.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   // Width of an index into n requesters (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module spi_rr_arbiter
   import spi_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   grant
);

   logic [IDX_W-1:0] idx_s;

   // Scan requesters starting from the pointer; the first hit wins.
   always_comb begin
      found = 1'b0;
      grant = {IDX_W{1'b0}};
      idx_s = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[idx_s]) begin
            found = 1'b1;
            grant = idx_s;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/spi_request_arbiter.sv
// Shares one 8-bit SPI engine among NUM_REQ requesters, one transfer at a time.
module spi_request_arbiter
   import spi_ctrl_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int RECOVER_CYCLES = 2
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*SPI_WORD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [SPI_WORD_W-1:0]         resp_data,
   output logic                          resp_err,
   output logic                          busy,
   output logic                          spi_start,
   output logic [SPI_WORD_W-1:0]         spi_tx_data,
   output logic [NUM_REQ-1:0]            spi_cs_sel,
   input  logic                          spi_done,
   input  logic [SPI_WORD_W-1:0]         spi_rx_data
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam int REC_W = cnt_width(RECOVER_CYCLES);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_CYCLES - 1);

   state_t                  state_r;
   state_t                  state_nx_s;
   logic [IDX_W-1:0]        ptr_r;
   logic [IDX_W-1:0]        g_r;
   logic [SPI_WORD_W-1:0]   tx_r;
   logic [SPI_WORD_W-1:0]   rx_r;
   logic                    err_r;
   logic [CNT_W-1:0]        to_cnt_r;
   logic [REC_W-1:0]        rec_cnt_r;
   logic                    found_s;
   logic [IDX_W-1:0]        grant_s;
   logic [NUM_REQ-1:0]      sel_oh_s;
   logic                    timeout_s;
   logic [SPI_WORD_W-1:0]   req_bytes_s [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
      assign req_bytes_s[i] = req_data[i*SPI_WORD_W +: SPI_WORD_W];
   end

   assign sel_oh_s  = NUM_REQ'(1) << g_r;
   assign timeout_s = (to_cnt_r == TO_LAST);

   spi_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr_r),
      .found (found_s),
      .grant (grant_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic and the combinational accept pulse.
   always_comb begin
      state_nx_s = state_r;
      req_ready  = {NUM_REQ{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (found_s && !rst) begin
               req_ready  = NUM_REQ'(1) << grant_s;
               state_nx_s = ST_START;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_START: state_nx_s = ST_WAIT;
         ST_WAIT: begin
            if (spi_done || timeout_s) begin
               state_nx_s = ST_RESP;
            end else begin
               state_nx_s = ST_WAIT;
            end
         end
         ST_RESP: state_nx_s = ST_RECOVER;
         ST_RECOVER: begin
            if (rec_cnt_r == REC_LAST) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_RECOVER;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Transfer latches, timeout/recovery counters and the round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r     <= {IDX_W{1'b0}};
         g_r       <= {IDX_W{1'b0}};
         tx_r      <= {SPI_WORD_W{1'b0}};
         rx_r      <= {SPI_WORD_W{1'b0}};
         err_r     <= 1'b0;
         to_cnt_r  <= {CNT_W{1'b0}};
         rec_cnt_r <= {REC_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  g_r  <= grant_s;
                  tx_r <= req_bytes_s[grant_s];
               end
            end
            ST_START: to_cnt_r <= {CNT_W{1'b0}};
            ST_WAIT: begin
               to_cnt_r <= to_cnt_r + CNT_W'(1);
               // A done pulse on the final cycle still counts as success.
               if (spi_done) begin
                  rx_r  <= spi_rx_data;
                  err_r <= 1'b0;
               end else if (timeout_s) begin
                  rx_r  <= {SPI_WORD_W{1'b0}};
                  err_r <= 1'b1;
               end
            end
            ST_RESP: begin
               ptr_r     <= (g_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : g_r + IDX_W'(1);
               rec_cnt_r <= {REC_W{1'b0}};
            end
            ST_RECOVER: rec_cnt_r <= rec_cnt_r + REC_W'(1);
            default: begin
               to_cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Output decode from registered state and latches.
   always_comb begin
      busy        = (state_r != ST_IDLE);
      spi_start   = 1'b0;
      spi_cs_sel  = {NUM_REQ{1'b0}};
      spi_tx_data = {SPI_WORD_W{1'b0}};
      resp_valid  = {NUM_REQ{1'b0}};
      resp_data   = {SPI_WORD_W{1'b0}};
      resp_err    = 1'b0;
      case (state_r)
         ST_START: begin
            spi_start   = 1'b1;
            spi_cs_sel  = sel_oh_s;
            spi_tx_data = tx_r;
         end
         ST_WAIT: begin
            spi_cs_sel  = sel_oh_s;
            spi_tx_data = tx_r;
         end
         ST_RESP: begin
            resp_valid = sel_oh_s;
            resp_data  = rx_r;
            resp_err   = err_r;
         end
         default: begin
            spi_start = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Self-checking bench for spi_request_arbiter (4 requesters, 64-cycle timeout, 2 recover cycles).
module tb_spi_request_arbiter;

   localparam int N = 4;
   localparam int T = 64;
   localparam int R = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*8-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  resp_valid;
   logic [7:0]    resp_data;
   logic          resp_err;
   logic          busy;
   logic          spi_start;
   logic [7:0]    spi_tx_data;
   logic [N-1:0]  spi_cs_sel;
   logic          spi_done;
   logic [7:0]    spi_rx_data;

   int n_checks = 0;
   int n_err    = 0;
   int m_ptr    = 0;

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] data;
      int          dly;     // WAIT cycle (1-based) carrying done; 0 or >T means never
      logic [7:0]  rx;
      int          exp_g;
      logic        exp_err;
   } vec_t;

   vec_t tbl [11];

   always #5 clk = ~clk;

   spi_request_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (T),
      .RECOVER_CYCLES (R)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_err    (resp_err),
      .busy        (busy),
      .spi_start   (spi_start),
      .spi_tx_data (spi_tx_data),
      .spi_cs_sel  (spi_cs_sel),
      .spi_done    (spi_done),
      .spi_rx_data (spi_rx_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ready"}, 32'(req_ready), 32'd0);
      chk({name, "_rvalid"}, 32'(resp_valid), 32'd0);
      chk({name, "_rdata"}, 32'(resp_data), 32'd0);
      chk({name, "_rerr"}, 32'(resp_err), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_start"}, 32'(spi_start), 32'd0);
      chk({name, "_tx"}, 32'(spi_tx_data), 32'd0);
      chk({name, "_cs"}, 32'(spi_cs_sel), 32'd0);
   endtask

   // Reference rule: first requester at or after the pointer, wrapping.
   function automatic int model_pick(input logic [3:0] v, input int p);
      int idx;
      for (int i = 0; i < N; i++) begin
         idx = (p + i) % N;
         if (v[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   // One full transfer, starting one idle cycle before acceptance.
   task automatic xfer(input logic [3:0] vld, input logic [31:0] data, input int dly,
                       input logic [7:0] rx, input int exp_g, input logic exp_err);
      logic [3:0] oh;
      logic [7:0] byte_v;
      logic [7:0] exp_d;
      oh     = 4'b0001 << exp_g;
      byte_v = 8'(data >> (8 * exp_g));
      exp_d  = exp_err ? 8'h00 : rx;
      // Idle cycle with a stray done pulse: must be ignored.
      req_valid = 4'h0; spi_done = 1'b1; spi_rx_data = 8'hEE; #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_resp", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      spi_done = 1'b0; req_valid = vld; req_data = data; #1;
      chk("grant", 32'(req_ready), 32'(oh));
      chk("grant_busy", 32'(busy), 32'd0);
      chk("grant_start", 32'(spi_start), 32'd0);
      @(posedge clk); #1;
      req_valid = vld & ~oh; #1;
      chk("start_pulse", 32'(spi_start), 32'd1);
      chk("start_cs", 32'(spi_cs_sel), 32'(oh));
      chk("start_tx", 32'(spi_tx_data), 32'(byte_v));
      chk("start_ready", 32'(req_ready), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      for (int k = 1; k <= T; k++) begin
         spi_done = (k == dly); spi_rx_data = rx; #1;
         chk("wait_cs", 32'(spi_cs_sel), 32'(oh));
         chk("wait_start", 32'(spi_start), 32'd0);
         chk("wait_tx", 32'(spi_tx_data), 32'(byte_v));
         chk("wait_resp", 32'(resp_valid), 32'd0);
         @(posedge clk); #1;
         spi_done = 1'b0;
         if (k == dly) break;
      end
      #1;
      chk("resp_valid", 32'(resp_valid), 32'(oh));
      chk("resp_data", 32'(resp_data), 32'(exp_d));
      chk("resp_err", 32'(resp_err), 32'(exp_err));
      chk("resp_cs", 32'(spi_cs_sel), 32'd0);
      chk("resp_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      for (int r = 0; r < R; r++) begin
         req_valid = 4'hF; spi_done = (r == 0); spi_rx_data = 8'h5F; #1;
         chk("rec_resp", 32'(resp_valid), 32'd0);
         chk("rec_ready", 32'(req_ready), 32'd0);
         chk("rec_busy", 32'(busy), 32'd1);
         chk("rec_cs", 32'(spi_cs_sel), 32'd0);
         chk("rec_tx", 32'(spi_tx_data), 32'd0);
         @(posedge clk); #1;
         spi_done = 1'b0;
      end
      req_valid = 4'h0;
      m_ptr = (exp_g + 1) % N;
   endtask

   initial begin
      int g;
      int dly;
      logic [3:0] v;
      rst = 1'b1; req_valid = 4'h0; req_data = 32'h0; spi_done = 1'b0; spi_rx_data = 8'h0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      tbl[0]  = '{4'hF, 32'h44332211, 3,  8'h10, 0, 1'b0};
      tbl[1]  = '{4'hF, 32'h88776655, 1,  8'h21, 1, 1'b0};
      tbl[2]  = '{4'hF, 32'hCCBBAA99, 7,  8'h32, 2, 1'b0};
      tbl[3]  = '{4'hF, 32'h00FFEEDD, 2,  8'h43, 3, 1'b0};
      tbl[4]  = '{4'hF, 32'h13579BDF, 5,  8'h54, 0, 1'b0};
      tbl[5]  = '{4'b0010, 32'h0000A500, 16, 8'h3C, 1, 1'b0};
      tbl[6]  = '{4'b0001, 32'h000000C3, 0,  8'h77, 0, 1'b1};
      tbl[7]  = '{4'b1000, 32'h7E000000, 64, 8'h5A, 3, 1'b0};
      tbl[8]  = '{4'b0110, 32'h00BEEF00, 65, 8'h66, 1, 1'b1};
      tbl[9]  = '{4'b1001, 32'hD00000E0, 1,  8'h99, 3, 1'b0};
      tbl[10] = '{4'b0101, 32'h00F0000F, 4,  8'hAB, 0, 1'b0};
      for (int i = 0; i < 11; i++) begin
         xfer(tbl[i].vld, tbl[i].data, tbl[i].dly, tbl[i].rx, tbl[i].exp_g, tbl[i].exp_err);
      end

      // Reset in the middle of WAIT: silent abort, pointer back to requester 0.
      req_valid = 4'hF; req_data = 32'h11223344; #1;
      chk("pre_rst_grant", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      req_valid = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; #1;
      chk_all_zero("rst_wait");
      for (int c = 0; c < 3; c++) begin
         spi_done = 1'b1; #1;
         chk("post_rst_resp", 32'(resp_valid), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
         @(posedge clk); #1;
         spi_done = 1'b0;
      end
      m_ptr = 0;
      xfer(4'hF, 32'hA1B2C3D4, 2, 8'h6E, 0, 1'b0);

      // Randomized transfers against the reference model.
      for (int i = 0; i < 40; i++) begin
         v = 4'($urandom_range(1, 15));
         if ($urandom_range(0, 3) == 0) begin
            dly = ($urandom_range(0, 1) == 1) ? T : 0;
         end else begin
            dly = $urandom_range(1, 20);
         end
         g = model_pick(v, m_ptr);
         xfer(v, $urandom, dly, 8'($urandom), g, (dly < 1 || dly > T));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
